// File: rtl/des3_scheduler_if.sv
// Requester/response bundle for des3_scheduler.
// slave = scheduler side, master = requester/consumer side.
interface des3_scheduler_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]     req_i;
   logic [64*NREQ-1:0]  req_data_i;
   logic [168*NREQ-1:0] req_key_i;
   logic [NREQ-1:0]     req_decrypt_i;
   logic [NREQ-1:0]     gnt_o;
   logic                resp_valid_o;
   logic                resp_ready_i;
   logic [IDW-1:0]      resp_id_o;
   logic [63:0]         resp_data_o;
   logic                resp_err_o;

   modport slave (
      input  req_i, req_data_i, req_key_i,
      input  req_decrypt_i, resp_ready_i,
      output gnt_o, resp_valid_o, resp_id_o,
      output resp_data_o, resp_err_o
   );

   modport master (
      output req_i, req_data_i, req_key_i,
      output req_decrypt_i, resp_ready_i,
      input  gnt_o, resp_valid_o, resp_id_o,
      input  resp_data_o, resp_err_o
   );
endinterface

// File: rtl/des3_scheduler.sv
// Round-robin job scheduler sharing one des3 core.
// Optional watchdog: define DES3_SCHED_WDOG_EN.
module des3_scheduler #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   des3_scheduler_if.slave bus,
   output logic        core_start_o,
   output logic        core_decrypt_o,
   output logic [63:0] core_in_o,
   output logic [55:0] core_key1_o,
   output logic [55:0] core_key2_o,
   output logic [55:0] core_key3_o,
   input  logic [63:0] core_out_i,
   input  logic        core_valid_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE, RUN, DONE, REL
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [63:0]     in_q, in_d;
   logic [167:0]    key_q, key_d;
   logic            dec_q, dec_d;
   logic [63:0]     data_q, data_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  win;
   logic            win_vld;
   logic [IDW:0]    idx;
   logic            wdog_hit;

`ifdef DES3_SCHED_WDOG_EN
   logic [15:0] cnt_q, cnt_d;

   assign wdog_hit = (cnt_q == 16'(TIMEOUT - 1));

   // Watchdog counts RUN cycles, zero elsewhere.
   always_comb begin
      cnt_d = '0;
      if (state_q == RUN) cnt_d = cnt_q + 16'd1;
   end

   // Watchdog counter register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end
`else
   assign wdog_hit = 1'b0;
`endif

   // Round-robin search starting at ptr, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ))
            idx = idx - (IDW+1)'(NREQ);
         if (!win_vld && bus.req_i[idx[IDW-1:0]]) begin
            win_vld = 1'b1;
            win     = idx[IDW-1:0];
         end
      end
   end

   // Next-state, operand capture and response logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      in_d    = in_q;
      key_d   = key_q;
      dec_d   = dec_q;
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      gnt     = '0;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               gnt[win] = 1'b1;
               in_d  = bus.req_data_i[64*int'(win) +: 64];
               key_d = bus.req_key_i[168*int'(win) +: 168];
               dec_d = bus.req_decrypt_i[win];
               id_d  = win;
               err_d = 1'b0;
               if (win == IDW'(NREQ - 1)) ptr_d = '0;
               else                       ptr_d = win + IDW'(1);
               state_d = RUN;
            end
         end
         RUN: begin
            if (core_valid_i) begin
               data_d  = core_out_i;
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = DONE;
            end else if (wdog_hit) begin
               data_d  = '0;
               err_d   = 1'b1;
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (valid_q && bus.resp_ready_i) begin
               valid_d = 1'b0;
               state_d = REL;
            end
         end
         REL: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         in_q    <= '0;
         key_q   <= '0;
         dec_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         in_q    <= in_d;
         key_q   <= key_d;
         dec_q   <= dec_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Grant is masked while reset is held so outputs read 0.
   assign bus.gnt_o        = gnt & {NREQ{wb_rst_ni}};
   assign bus.resp_valid_o = valid_q;
   assign bus.resp_id_o    = id_q;
   assign bus.resp_data_o  = data_q;
   assign bus.resp_err_o   = err_q;

   assign core_start_o   = (state_q == RUN);
   assign core_decrypt_o = dec_q;
   assign core_in_o      = in_q;
   assign core_key1_o    = key_q[167:112];
   assign core_key2_o    = key_q[111:56];
   assign core_key3_o    = key_q[55:0];
   assign busy_o         = (state_q != IDLE);

endmodule
